// File: rtl/hdmi_cfg_seq_if.sv
// Write-request channel between hdmi_cfg_seq (master) and the I2C write engine (slave).
interface hdmi_cfg_seq_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] dev_addr;
  logic [7:0] wr_reg;
  logic [7:0] wr_data;
  logic       wr_done;
  logic       wr_nack;

  modport master (
    output wr_valid, dev_addr, wr_reg, wr_data,
    input  wr_ready, wr_done, wr_nack
  );

  modport slave (
    input  wr_valid, dev_addr, wr_reg, wr_data,
    output wr_ready, wr_done, wr_nack
  );
endinterface

// File: rtl/hdmi_cfg_seq.sv
// Power-up register sequencer for the HDMI transmitter at I2C address 0x72, with NACK retry.
// Optional hot-plug re-initialisation is built when HPD_REINIT_EN is defined.
module hdmi_cfg_seq #(
  parameter int unsigned STARTUP_DELAY = 32'd500000,
  parameter int unsigned GAP_CYCLES    = 32'd1000,
  parameter int unsigned RETRY_MAX     = 32'd3
`ifdef HPD_REINIT_EN
  , parameter int unsigned HPD_DEBOUNCE = 32'd250000
`endif
) (
  input  logic                  clk50,
  input  logic                  reset_n,
  input  logic                  restart,
`ifdef HPD_REINIT_EN
  input  logic                  hpd,
`endif
  hdmi_cfg_seq_if.master        wr,
  output logic [3:0]            cfg_index,
  output logic                  cfg_done,
  output logic                  cfg_error,
  output logic                  hdmi_reset_n
);

  localparam logic [3:0] LAST_IDX    = 4'd11;
  localparam logic [3:0] RETRY_LIMIT = 4'(RETRY_MAX);

  typedef enum logic [2:0] {
    WAIT_PWR  = 3'd0,
    ISSUE     = 3'd1,
    WAIT_RESP = 3'd2,
    GAP       = 3'd3,
    DONE      = 3'd4,
    ERROR     = 3'd5
  } state_t;

  state_t      state_r;
  logic [31:0] cnt_r;
  logic [3:0]  idx_r;
  logic [3:0]  retry_r;
  logic        pend_r;
  logic        wr_valid_r;
  logic        cfg_done_r;
  logic        cfg_error_r;
  logic        hdmi_rst_n_r;
  logic        restart_req_s;
  logic        service_s;
  logic        hpd_rise_s;
  logic        hpd_fall_s;
  logic [7:0]  reg_s;
  logic [7:0]  data_s;

  // {register, data} for each table entry
  function automatic logic [15:0] cfg_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    cfg_entry = 16'h4110;
      4'd1:    cfg_entry = 16'h9803;
      4'd2:    cfg_entry = 16'h9AE0;
      4'd3:    cfg_entry = 16'h9C30;
      4'd4:    cfg_entry = 16'h9D61;
      4'd5:    cfg_entry = 16'hA2A4;
      4'd6:    cfg_entry = 16'hA3A4;
      4'd7:    cfg_entry = 16'hE0D0;
      4'd8:    cfg_entry = 16'hF900;
      4'd9:    cfg_entry = 16'h1500;
      4'd10:   cfg_entry = 16'h1630;
      4'd11:   cfg_entry = 16'hAF06;
      default: cfg_entry = 16'h0000;
    endcase
  endfunction

`ifdef HPD_REINIT_EN
  logic [1:0]  hpd_sync_r;
  logic        hpd_deb_r;
  logic [31:0] deb_cnt_r;
  logic        deb_flip_s;

  assign deb_flip_s = (hpd_sync_r[1] != hpd_deb_r) && (deb_cnt_r == HPD_DEBOUNCE - 32'd1);
  assign hpd_rise_s = deb_flip_s && hpd_sync_r[1];
  assign hpd_fall_s = deb_flip_s && !hpd_sync_r[1];

  // HPD synchronizer and debouncer: level follows input only after it has been stable long enough
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      hpd_sync_r <= 2'b00;
      hpd_deb_r  <= 1'b0;
      deb_cnt_r  <= 32'd0;
    end else begin
      hpd_sync_r <= {hpd_sync_r[0], hpd};
      if (hpd_sync_r[1] == hpd_deb_r) begin
        deb_cnt_r <= 32'd0;
      end else if (deb_flip_s) begin
        hpd_deb_r <= hpd_sync_r[1];
        deb_cnt_r <= 32'd0;
      end else begin
        deb_cnt_r <= deb_cnt_r + 32'd1;
      end
    end
  end
`else
  assign hpd_rise_s = 1'b0;
  assign hpd_fall_s = 1'b0;
`endif

  assign restart_req_s = restart | pend_r | hpd_rise_s;

  // Table lookup for the current entry
  always_comb begin
    {reg_s, data_s} = cfg_entry(idx_r);
  end

  // A restart never abandons an accepted request; it waits for that request's wr_done
  always_comb begin
    service_s = 1'b0;
    if (restart_req_s) begin
      case (state_r)
        ISSUE:     service_s = !wr.wr_ready;
        WAIT_RESP: service_s = wr.wr_done;
        default:   service_s = 1'b1;
      endcase
    end else begin
      service_s = 1'b0;
    end
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= WAIT_PWR;
      cnt_r        <= 32'd0;
      idx_r        <= 4'd0;
      retry_r      <= 4'd0;
      pend_r       <= 1'b0;
      wr_valid_r   <= 1'b0;
      cfg_done_r   <= 1'b0;
      cfg_error_r  <= 1'b0;
      hdmi_rst_n_r <= 1'b0;
    end else if (service_s) begin
      state_r      <= WAIT_PWR;
      cnt_r        <= 32'd0;
      idx_r        <= 4'd0;
      retry_r      <= 4'd0;
      pend_r       <= 1'b0;
      wr_valid_r   <= 1'b0;
      cfg_done_r   <= 1'b0;
      cfg_error_r  <= 1'b0;
      hdmi_rst_n_r <= 1'b0;
    end else begin
      pend_r <= restart_req_s;
      case (state_r)
        WAIT_PWR: begin
          if (cnt_r == STARTUP_DELAY - 32'd1) begin
            state_r    <= ISSUE;
            cnt_r      <= 32'd0;
            idx_r      <= 4'd0;
            retry_r    <= 4'd0;
            wr_valid_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 32'd1;
          end
        end
        ISSUE: begin
          if (wr.wr_ready) begin
            state_r    <= WAIT_RESP;
            wr_valid_r <= 1'b0;
          end
        end
        WAIT_RESP: begin
          if (wr.wr_done) begin
            if (!wr.wr_nack) begin
              if (idx_r == LAST_IDX) begin
                state_r      <= DONE;
                cfg_done_r   <= 1'b1;
                hdmi_rst_n_r <= 1'b1;
              end else begin
                state_r <= GAP;
                cnt_r   <= 32'd0;
                idx_r   <= idx_r + 4'd1;
                retry_r <= 4'd0;
              end
            end else if (retry_r < RETRY_LIMIT) begin
              state_r <= GAP;
              cnt_r   <= 32'd0;
              retry_r <= retry_r + 4'd1;
            end else begin
              state_r      <= ERROR;
              cfg_error_r  <= 1'b1;
              hdmi_rst_n_r <= 1'b0;
            end
          end
        end
        GAP: begin
          if (cnt_r == GAP_CYCLES - 32'd1) begin
            state_r    <= ISSUE;
            cnt_r      <= 32'd0;
            wr_valid_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 32'd1;
          end
        end
        DONE:  state_r <= DONE;
        ERROR: state_r <= ERROR;
        default: begin
          state_r    <= WAIT_PWR;
          cnt_r      <= 32'd0;
          wr_valid_r <= 1'b0;
        end
      endcase
      // Losing hot-plug holds the video stage in reset without disturbing the sequence
      if (hpd_fall_s) begin
        hdmi_rst_n_r <= 1'b0;
      end
    end
  end

  assign wr.wr_valid   = wr_valid_r;
  assign wr.dev_addr   = 8'h72;
  assign wr.wr_reg     = reg_s;
  assign wr.wr_data    = data_s;
  assign cfg_index     = idx_r;
  assign cfg_done      = cfg_done_r;
  assign cfg_error     = cfg_error_r;
  assign hdmi_reset_n  = hdmi_rst_n_r;

endmodule

// File: tb/tb_hdmi_cfg_seq.sv
// Self-checking bench for hdmi_cfg_seq: table vectors, hand-written restart sequences and
// randomized NACK/latency runs checked against a request-sequence model.
module tb_hdmi_cfg_seq;
  localparam int SD   = 10;
  localparam int GAP  = 4;
  localparam int RMAX = 3;

  logic       clk50   = 1'b0;
  logic       reset_n = 1'b0;
  logic       restart = 1'b0;
`ifdef HPD_REINIT_EN
  logic       hpd     = 1'b0;
`endif
  logic [3:0] cfg_index;
  logic       cfg_done;
  logic       cfg_error;
  logic       hdmi_reset_n;

  hdmi_cfg_seq_if ifc();

  hdmi_cfg_seq #(
    .STARTUP_DELAY(SD),
    .GAP_CYCLES(GAP),
    .RETRY_MAX(RMAX)
`ifdef HPD_REINIT_EN
    , .HPD_DEBOUNCE(8)
`endif
  ) dut (
    .clk50(clk50),
    .reset_n(reset_n),
    .restart(restart),
`ifdef HPD_REINIT_EN
    .hpd(hpd),
`endif
    .wr(ifc),
    .cfg_index(cfg_index),
    .cfg_done(cfg_done),
    .cfg_error(cfg_error),
    .hdmi_reset_n(hdmi_reset_n)
  );

  always #5 clk50 = ~clk50;

  typedef struct {
    logic [47:0] nacks;     // NACK count per entry, entry i in nibble i
    int          exp_reqs;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  vec_t vecs [6];
  logic [7:0] spec_reg [12] = '{8'h41, 8'h98, 8'h9A, 8'h9C, 8'h9D, 8'hA2,
                                8'hA3, 8'hE0, 8'hF9, 8'h15, 8'h16, 8'hAF};
  logic [7:0] spec_dat [12] = '{8'h10, 8'h03, 8'hE0, 8'h30, 8'h61, 8'hA4,
                                8'hA4, 8'hD0, 8'h00, 8'h00, 8'h30, 8'h06};

  int nack_plan [12];
  int exp_q [$];
  bit exp_err;
  int n_req;
  int n_cmp;
  int n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ereg(input int i);
    return (i >= 0 && i < 12) ? spec_reg[i] : 8'h00;
  endfunction

  function automatic logic [7:0] edat(input int i);
    return (i >= 0 && i < 12) ? spec_dat[i] : 8'h00;
  endfunction

  // Reference: each entry is attempted once plus once per NACK, up to RMAX+1 attempts
  function automatic void build_exp(input int restart_at);
    exp_q.delete();
    exp_err = 1'b0;
    for (int i = 0; i <= restart_at; i++) exp_q.push_back(i);
    for (int i = 0; i < 12 && !exp_err; i++) begin
      int tries;
      tries = (nack_plan[i] > RMAX) ? RMAX + 1 : nack_plan[i] + 1;
      repeat (tries) exp_q.push_back(i);
      if (nack_plan[i] > RMAX) exp_err = 1'b1;
    end
  endfunction

  task automatic do_reset();
    ifc.wr_ready = 1'b0;
    ifc.wr_done  = 1'b0;
    ifc.wr_nack  = 1'b0;
    restart      = 1'b0;
    @(negedge clk50);
    reset_n = 1'b0;
    repeat (2) @(negedge clk50);
    check("rst_valid", ifc.wr_valid, 0);
    check("rst_done", cfg_done, 0);
    check("rst_error", cfg_error, 0);
    check("rst_hdmi_reset_n", hdmi_reset_n, 0);
    check("rst_index", cfg_index, 0);
    reset_n = 1'b1;
  endtask

  // Behaves as the I2C engine until cfg_done/cfg_error or a timeout
  task automatic serve(input int stall_first, input int restart_at, input int max_rdy, input int max_lat);
    int att [12];
    int cyc, d, lat, gap, ei;
    bit first, rs_used, rs_pending, fin, nk;
    logic [3:0] i0;
    for (int i = 0; i < 12; i++) att[i] = 0;
    n_req = 0; first = 1'b1; rs_used = 1'b0; rs_pending = 1'b0; fin = 1'b0;
    cyc = 0;
    while (!ifc.wr_valid && cyc < 200) begin
      @(negedge clk50);
      cyc++;
    end
    check("startup_delay", cyc, SD);
    check("dev_addr", ifc.dev_addr, 8'h72);
    if (!ifc.wr_valid) fin = 1'b1;
    while (!fin) begin
      ei = (n_req < exp_q.size()) ? exp_q[n_req] : -1;
      i0 = cfg_index;
      check("req_index", cfg_index, ei);
      check("req_reg", ifc.wr_reg, ereg(ei));
      check("req_data", ifc.wr_data, edat(ei));
      d = first ? stall_first : int'($urandom_range(max_rdy, 0));
      first = 1'b0;
      for (int k = 0; k < d; k++) begin
        @(negedge clk50);
        check("stall_valid", ifc.wr_valid, 1);
        check("stall_reg", ifc.wr_reg, ereg(ei));
        check("stall_data", ifc.wr_data, edat(ei));
      end
      ifc.wr_ready = 1'b1;
      @(negedge clk50);
      ifc.wr_ready = 1'b0;
      n_req++;
      check("valid_after_handshake", ifc.wr_valid, 0);
      nk = 1'b0;
      if (i0 < 4'd12) begin
        nk = att[i0] < nack_plan[i0];
        att[i0]++;
      end
      if (restart_at >= 0 && int'(i0) == restart_at && !rs_used) begin
        restart = 1'b1;
        @(negedge clk50);
        restart = 1'b0;
        rs_used = 1'b1;
        rs_pending = 1'b1;
        lat = 4;
      end else begin
        lat = int'($urandom_range(max_lat, 0));
      end
      repeat (lat) begin
        @(negedge clk50);
        check("idle_in_resp", ifc.wr_valid, 0);
      end
      ifc.wr_done = 1'b1;
      ifc.wr_nack = nk;
      gap = 0;
      do begin
        @(negedge clk50);
        ifc.wr_done = 1'b0;
        ifc.wr_nack = 1'b0;
        gap++;
      end while (!ifc.wr_valid && !cfg_done && !cfg_error && gap < 100);
      if (cfg_done || cfg_error) begin
        fin = 1'b1;
        check("end_latency", gap, 1);
      end else begin
        check("gap_to_next_req", gap, rs_pending ? SD + 1 : GAP + 1);
      end
      rs_pending = 1'b0;
      if (gap >= 100 || n_req > 64) fin = 1'b1;
    end
  endtask

  task automatic check_final(input string tag);
    int saw;
    check({tag, "_req_count"}, n_req, exp_q.size());
    check({tag, "_done"}, cfg_done, !exp_err);
    check({tag, "_error"}, cfg_error, exp_err);
    check({tag, "_hdmi_reset_n"}, hdmi_reset_n, !exp_err);
    saw = 0;
    repeat (8) begin
      @(negedge clk50);
      if (ifc.wr_valid) saw++;
    end
    check({tag, "_no_extra_req"}, saw, 0);
  endtask

  task automatic wait_req(output int k);
    k = 1;
    while (!ifc.wr_valid && k < 100) begin
      @(negedge clk50);
      k++;
    end
  endtask

  // Restart from DONE, restart while stalled in ISSUE, restart on the accepting cycle
  task automatic restart_sequences();
    int k;
    restart = 1'b1;
    @(negedge clk50);
    restart = 1'b0;
    check("done_clears", cfg_done, 0);
    check("done_restart_hdmi", hdmi_reset_n, 0);
    wait_req(k);
    check("rs_done_delay", k, SD + 1);
    check("rs_done_index", cfg_index, 0);
    check("rs_done_reg", ifc.wr_reg, 8'h41);
    check("rs_done_data", ifc.wr_data, 8'h10);
    restart = 1'b1;
    @(negedge clk50);
    restart = 1'b0;
    check("issue_restart_drop", ifc.wr_valid, 0);
    wait_req(k);
    check("rs_issue_delay", k, SD + 1);
    restart = 1'b1;
    ifc.wr_ready = 1'b1;
    @(negedge clk50);
    restart = 1'b0;
    ifc.wr_ready = 1'b0;
    check("accept_with_restart", ifc.wr_valid, 0);
    repeat (3) begin
      @(negedge clk50);
      check("deferred_idle", ifc.wr_valid, 0);
    end
    ifc.wr_done = 1'b1;
    @(negedge clk50);
    ifc.wr_done = 1'b0;
    wait_req(k);
    check("rs_deferred_delay", k, SD + 1);
    check("rs_deferred_index", cfg_index, 0);
  endtask

  task automatic restart_from_error();
    int k;
    restart = 1'b1;
    @(negedge clk50);
    restart = 1'b0;
    check("error_clears", cfg_error, 0);
    wait_req(k);
    check("rs_error_delay", k, SD + 1);
    check("rs_error_index", cfg_index, 0);
  endtask

  initial begin
    int r;
    n_cmp = 0;
    n_bad = 0;
    vecs[0] = '{48'h000000000000, 12, 1'b1, 1'b0};
    vecs[1] = '{48'h000000002000, 14, 1'b1, 1'b0};
    vecs[2] = '{48'h000000000004,  4, 1'b0, 1'b1};
    vecs[3] = '{48'h300000000000, 15, 1'b1, 1'b0};
    vecs[4] = '{48'h000000400000,  9, 1'b0, 1'b1};
    vecs[5] = '{48'h000030000100, 16, 1'b1, 1'b0};

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 12; i++) nack_plan[i] = int'(vecs[v].nacks[i*4 +: 4]);
      build_exp(-1);
      do_reset();
      serve(0, -1, 1, 2);
      check("vec_req_count", n_req, vecs[v].exp_reqs);
      check("vec_done", cfg_done, vecs[v].exp_done);
      check("vec_error", cfg_error, vecs[v].exp_err);
      check_final("vec");
      if (v == 0) restart_sequences();
      if (v == 2) restart_from_error();
    end

    // 20-cycle ready stall on the first request, then restart during entry 5's response
    for (int i = 0; i < 12; i++) nack_plan[i] = 0;
    build_exp(5);
    do_reset();
    serve(20, 5, 2, 2);
    check_final("stall_restart");

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 12; i++) begin
        r = int'($urandom_range(99, 0));
        nack_plan[i] = (r < 70) ? 0 : (r < 85) ? 1 : (r < 93) ? 2 : (r < 97) ? 3 : 4;
      end
      build_exp(-1);
      do_reset();
      serve(0, -1, 3, 3);
      check_final("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time limit so a stuck DUT cannot hang the run
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared so far", n_cmp);
    $fatal(1);
  end
endmodule
